// File: rtl/dropout_pkg.sv
// rtl/dropout_pkg.sv - shared types, constants and helpers for the dropout mask scheduler
package dropout_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Number of dropped lanes (zero bits) in an 8-lane keep mask.
    function automatic logic [3:0] count_zeros(input logic [7:0] m);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, ~m[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dropout_lfsr.sv
// rtl/dropout_lfsr.sv - Galois right-shift LFSR with load and step enables
//   Ports: clk, rst_n (async, active-low), i_load/i_load_val (load has priority),
//   i_step (advance one state), o_byte (low 8 bits used for the drop decision).
module dropout_lfsr
    import dropout_pkg::*;
#(
    parameter int          W    = 16,
    parameter logic [W-1:0] TAPS = LFSR_TAPS,
    parameter logic [W-1:0] SEED = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_step,
    output logic [7:0]   o_byte
);

    logic [W-1:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            r_lfsr <= i_load_val;
        end else if (i_step) begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
        end
    end

    assign o_byte = r_lfsr[7:0];

endmodule

// File: rtl/dropout_mask_scheduler.sv
// rtl/dropout_mask_scheduler.sv - per-sample 8-lane dropout keep-mask generator
//   Ports: clk, rst_n (async, active-low), ena (freeze), train_mode, drop_thr,
//   seed_load/seed_val, req_valid/req_ready (request handshake),
//   mask_valid/mask/mask_ready (mask handshake), busy, drop_count.
//   Optional macro DROPOUT_STATS_EN builds the saturating dropped-lane counter;
//   without it drop_count is tied to zero.
module dropout_mask_scheduler
    import dropout_pkg::*;
#(
    parameter int               LANES  = 8,
    parameter int               LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              train_mode,
    input  logic [7:0]        drop_thr,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    input  logic              req_valid,
    output logic              req_ready,
    output logic              mask_valid,
    output logic [LANES-1:0]  mask,
    input  logic              mask_ready,
    output logic              busy,
    output logic [15:0]       drop_count
);

    localparam int IDX_W = $clog2(LANES);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_thr;
    logic [LANES-1:0]   r_mask;
    logic [7:0]         w_lfsr_byte;
    logic               w_idle;
    logic               w_accept;
    logic               w_seed_ld;
    logic               w_step;
    logic               w_keep;
    logic [LFSR_W-1:0]  w_seed;

    assign w_idle    = (r_state == IDLE);
    assign w_accept  = ena & w_idle & req_valid;
    // A seed load shares the IDLE cycle with an acceptance; GEN starts on the
    // following edge, so the first step already sees the new seed.
    assign w_seed_ld = ena & w_idle & seed_load;
    assign w_step    = ena & (r_state == GEN);
    assign w_keep    = (w_lfsr_byte >= r_thr);
    assign w_seed    = (seed_val == '0) ? SEED : seed_val;

    dropout_lfsr #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_seed_ld),
        .i_load_val (w_seed),
        .i_step     (w_step),
        .o_byte     (w_lfsr_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = ena & w_idle;
        mask_valid = (r_state == HOLD);
        busy       = !w_idle;
        case (r_state)
            IDLE: if (w_accept) w_next = train_mode ? GEN : HOLD;
            GEN:  if (ena && (r_idx == IDX_W'(LANES - 1))) w_next = HOLD;
            HOLD: if (ena && mask_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Lane index, latched threshold and mask; the mask bits are rebuilt one
    // lane per GEN cycle, so stale bits from the last sample are overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_thr  <= 8'd0;
            r_mask <= '1;
        end else if (w_accept) begin
            r_idx <= '0;
            r_thr <= drop_thr;
            if (!train_mode) begin
                r_mask <= '1;
            end
        end else if (w_step) begin
            r_mask[r_idx] <= w_keep;
            r_idx         <= r_idx + 1'b1;
        end
    end

    assign mask = r_mask;

`ifdef DROPOUT_STATS_EN
    logic [15:0] r_drop_count;
    logic [16:0] w_sum;

    assign w_sum = {1'b0, r_drop_count} + {13'd0, count_zeros(r_mask)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= 16'h0000;
        end else if (w_seed_ld) begin
            r_drop_count <= 16'h0000;
        end else if (ena && (r_state == HOLD) && mask_ready) begin
            r_drop_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 16'h0000;
`endif

endmodule
